// File: rtl/bit_count_checker_if.sv
// Bus between the 4-bit bit counter (master) and its receive-side checker (slave).
// Carries the count bits r1..r4 plus the checker's status and counters.
interface bit_count_checker_if #(
  parameter int ERR_CNT_W = 8,
  parameter int WRAP_W    = 8
);
  logic                 r1;
  logic                 r2;
  logic                 r3;
  logic                 r4;
  logic                 locked;
  logic                 mismatch;
  logic                 fault;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WRAP_W-1:0]    wrap_count;

  modport master (
    output r1, r2, r3, r4,
    input  locked, mismatch, fault, err_count, wrap_count
  );

  modport slave (
    input  r1, r2, r3, r4,
    output locked, mismatch, fault, err_count, wrap_count
  );
endinterface

// File: rtl/bit_count_checker.sv
// Receive-side monitor for the 4-bit bit counter: locks on the first sample after
// reset, then expects +1 (mod 16) every clock and reports mismatches and faults.
module bit_count_checker #(
  parameter int ERR_CNT_W = 8,
  parameter int WRAP_W    = 8,
  parameter int MAX_ERR   = 3
) (
  input  logic               clk,
  input  logic               rst,
  bit_count_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_SAT   = '1;
  localparam logic [WRAP_W-1:0]    WRAP_SAT  = '1;
  localparam logic [8:0]           MAX_ERR_L = 9'(MAX_ERR);

  state_t               state_q, state_d;
  logic [3:0]           expected_q, expected_d;
  logic [7:0]           consec_q, consec_d;
  logic                 locked_q, locked_d;
  logic                 mismatch_q, mismatch_d;
  logic                 fault_q, fault_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [WRAP_W-1:0]    wrap_count_q, wrap_count_d;

  logic [3:0]           sample;
  logic [3:0]           sample_inc;
  logic [8:0]           consec_inc;

  assign sample     = {bus.r4, bus.r3, bus.r2, bus.r1};
  assign sample_inc = sample + 4'd1;
  assign consec_inc = {1'b0, consec_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    consec_d     = consec_q;
    locked_d     = locked_q;
    mismatch_d   = 1'b0;
    fault_d      = fault_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    case (state_q)
      ACQUIRE: begin
        expected_d = sample_inc;
        state_d    = TRACK;
        locked_d   = 1'b1;
      end

      TRACK: begin
        // Always resync to the observed value so a single glitch costs at most two errors.
        expected_d = sample_inc;
        if (sample == expected_q) begin
          consec_d = 8'd0;
          if (sample == 4'd0 && wrap_count_q != WRAP_SAT) begin
            wrap_count_d = wrap_count_q + WRAP_W'(1);
          end
        end else begin
          mismatch_d = 1'b1;
          consec_d   = consec_inc[7:0];
          if (err_count_q != ERR_SAT) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
          if (consec_inc == MAX_ERR_L) begin
            state_d  = FAULT;
            locked_d = 1'b0;
            fault_d  = 1'b1;
          end
        end
      end

      FAULT: begin
        locked_d = 1'b0;
        fault_d  = 1'b1;
      end

      default: begin
        state_d  = ACQUIRE;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACQUIRE;
      expected_q   <= 4'd0;
      consec_q     <= 8'd0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      fault_q      <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      consec_q     <= consec_d;
      locked_q     <= locked_d;
      mismatch_q   <= mismatch_d;
      fault_q      <= fault_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.fault      = fault_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;

endmodule
